// File: rtl/ram_dp_be_init_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM with fill engine.
package ram_pkg;

   // Fill engine states
   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Widest data word the lane-merge helper handles
   localparam int unsigned MAX_W = 512;

   function automatic int unsigned lanes(input int unsigned width, input int unsigned byte_w);
      return width / byte_w;
   endfunction

   // Bit b takes new_word when its lane enable (be[b / byte_w]) is set
   function automatic logic [MAX_W-1:0] merge_lanes(input logic [MAX_W-1:0] old_word,
                                                    input logic [MAX_W-1:0] new_word,
                                                    input logic [MAX_W-1:0] be,
                                                    input int unsigned      byte_w);
      logic [MAX_W-1:0] res;
      for (int unsigned b = 0; b < MAX_W; b++) begin
         res[b] = be[b / byte_w] ? new_word[b] : old_word[b];
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_dp_be_init_if.sv
// One RAM access port: request side driven by the master, response by the RAM.
interface ram_dp_be_init_if #(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned LANES     = 8,
   parameter int unsigned ADDR_BITS = 11
);
   logic                 en;
   logic                 we;
   logic [LANES-1:0]     be;
   logic [ADDR_BITS-1:0] addr;
   logic [WIDTH-1:0]     w_data;
   logic [WIDTH-1:0]     r_data;
   logic                 r_valid;

   modport master (
      output en, we, be, addr, w_data,
      input  r_data, r_valid
   );

   modport slave (
      input  en, we, be, addr, w_data,
      output r_data, r_valid
   );
endinterface

// File: rtl/ram_dp_be_init_init_ctrl.sv
// Fill engine: walks every word index once, one per cycle, while busy is high.
module ram_init_ctrl
   import ram_pkg::*;
#(
   parameter int unsigned DEPTH         = 2048,
   parameter int unsigned IDX_W         = 11,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_req,
   output logic             busy,
   output logic             fill_we,
   output logic [IDX_W-1:0] fill_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam state_e           RESET_ST = INIT_ON_RESET ? ST_INIT : ST_READY;

   state_e state;

   // FSM with fill counter; busy is registered alongside the state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RESET_ST;
         busy     <= INIT_ON_RESET;
         fill_idx <= '0;
      end else begin
         unique case (state)
            ST_READY: begin
               if (clr_req) begin
                  state    <= ST_INIT;
                  busy     <= 1'b1;
                  fill_idx <= '0;
               end
            end
            ST_INIT: begin
               if (fill_idx == LAST_IDX) begin
                  state    <= ST_READY;
                  busy     <= 1'b0;
                  fill_idx <= '0;
               end else begin
                  fill_idx <= fill_idx + IDX_W'(1);
               end
            end
            default: begin
               state <= ST_READY;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign fill_we = (state == ST_INIT);

endmodule

// File: rtl/ram_dp_be_init.sv
// True dual-port RAM with byte-lane writes, write-first responses, port-A-priority
// collision merge, 1- or 2-cycle read latency and a fill-with-INIT_VALUE engine.
module ram_dp_be_init
   import ram_pkg::*;
#(
   parameter int unsigned      WIDTH         = 64,
   parameter int unsigned      BYTE_W        = 8,
   parameter int unsigned      DEPTH         = 2048,
   parameter int unsigned      ADDR_BITS     = 11,
   parameter logic [WIDTH-1:0] INIT_VALUE    = '1,
   parameter int unsigned      READ_LATENCY  = 1,
   parameter bit               INIT_ON_RESET = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_req,
   output logic            busy,
   ram_dp_be_init_if.slave port_a,
   ram_dp_be_init_if.slave port_b
);

   localparam int unsigned LANES = lanes(WIDTH, BYTE_W);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   // One extra bit so DEPTH == 2**ADDR_BITS still compares correctly
   localparam int unsigned CMP_W = ADDR_BITS + 1;

   if (WIDTH % BYTE_W != 0) begin : g_chk_lanes
      $error("WIDTH must be a multiple of BYTE_W");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
      $error("READ_LATENCY must be 1 or 2");
   end
   if (ADDR_BITS < 32 && (32'd1 << ADDR_BITS) < DEPTH) begin : g_chk_addr
      $error("ADDR_BITS too narrow for DEPTH");
   end
   if (DEPTH < 2 || WIDTH > MAX_W) begin : g_chk_size
      $error("DEPTH must be >= 2 and WIDTH <= MAX_W");
   end

   function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] old_word,
                                                input logic [WIDTH-1:0] new_word,
                                                input logic [LANES-1:0] be);
      return WIDTH'(merge_lanes(MAX_W'(old_word), MAX_W'(new_word), MAX_W'(be), BYTE_W));
   endfunction

   logic [WIDTH-1:0] mem [DEPTH];

   logic             fill_we;
   logic [IDX_W-1:0] fill_idx;

   ram_init_ctrl #(
      .DEPTH         (DEPTH),
      .IDX_W         (IDX_W),
      .INIT_ON_RESET (INIT_ON_RESET)
   ) u_init_ctrl (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .busy     (busy),
      .fill_we  (fill_we),
      .fill_idx (fill_idx)
   );

   logic             acc_a, acc_b, in_a, in_b, wr_a, wr_b, collide;
   logic [IDX_W-1:0] idx_a, idx_b;
   logic [WIDTH-1:0] stored_a, stored_b, solo_a, solo_b, both_w, final_a, final_b;

   // Per-port access decode, lane merge and shared-address collision resolution
   always_comb begin
      acc_a    = port_a.en && !busy && rst;
      acc_b    = port_b.en && !busy && rst;
      in_a     = CMP_W'(port_a.addr) < CMP_W'(DEPTH);
      in_b     = CMP_W'(port_b.addr) < CMP_W'(DEPTH);
      idx_a    = port_a.addr[IDX_W-1:0];
      idx_b    = port_b.addr[IDX_W-1:0];
      stored_a = in_a ? mem[idx_a] : INIT_VALUE;
      stored_b = in_b ? mem[idx_b] : INIT_VALUE;
      solo_a   = port_a.we ? merge_w(stored_a, port_a.w_data, port_a.be) : stored_a;
      solo_b   = port_b.we ? merge_w(stored_b, port_b.w_data, port_b.be) : stored_b;
      collide  = acc_a && acc_b && (port_a.addr == port_b.addr);
      // B's lanes go in first so A's enabled lanes override them
      both_w   = port_a.we ? merge_w(solo_b, port_a.w_data, port_a.be) : solo_b;
      final_a  = !in_a ? INIT_VALUE : (collide ? both_w : solo_a);
      final_b  = !in_b ? INIT_VALUE : (collide ? both_w : solo_b);
      wr_a     = acc_a && port_a.we && in_a;
      wr_b     = acc_b && port_b.we && in_b;
   end

   // Array update: the fill owns the array while busy, ports are gated off then
   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[fill_idx] <= INIT_VALUE;
      end else begin
         if (wr_a) mem[idx_a] <= final_a;
         if (wr_b) mem[idx_b] <= final_b;
      end
   end

   logic [WIDTH-1:0] rd_data_a_q, rd_data_b_q;
   logic             rd_valid_a_q, rd_valid_b_q;

   // First response stage; data holds when no access completes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_a_q  <= INIT_VALUE;
         rd_data_b_q  <= INIT_VALUE;
         rd_valid_a_q <= 1'b0;
         rd_valid_b_q <= 1'b0;
      end else begin
         rd_valid_a_q <= acc_a;
         rd_valid_b_q <= acc_b;
         if (acc_a) rd_data_a_q <= final_a;
         if (acc_b) rd_data_b_q <= final_b;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] out_data_a_q, out_data_b_q;
      logic             out_valid_a_q, out_valid_b_q;

      // Second response stage; keeps running through a fill so in-flight reads land
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            out_data_a_q  <= INIT_VALUE;
            out_data_b_q  <= INIT_VALUE;
            out_valid_a_q <= 1'b0;
            out_valid_b_q <= 1'b0;
         end else begin
            out_valid_a_q <= rd_valid_a_q;
            out_valid_b_q <= rd_valid_b_q;
            if (rd_valid_a_q) out_data_a_q <= rd_data_a_q;
            if (rd_valid_b_q) out_data_b_q <= rd_data_b_q;
         end
      end

      assign port_a.r_data  = out_data_a_q;
      assign port_a.r_valid = out_valid_a_q;
      assign port_b.r_data  = out_data_b_q;
      assign port_b.r_valid = out_valid_b_q;
   end else begin : g_lat1
      assign port_a.r_data  = rd_data_a_q;
      assign port_a.r_valid = rd_valid_a_q;
      assign port_b.r_data  = rd_data_b_q;
      assign port_b.r_valid = rd_valid_b_q;
   end

endmodule
